pipe_ctrl_gen: RTL and testbench

- Parametrised pipeline stall/flush controller for the in-order CPU.
- Any stage can request a stall. The highest requesting stage freezes itself and every upstream stage.
- Adds an exception flush sequencer with a latched redirect PC, a stall watchdog, and a saturating stall-cycle performance counter.
- Sits beside the pipeline registers, PC unit and exception logic; drives their stall/flush inputs.

---
 rtl/pipe_ctrl_gen_if.sv | 34 +++
 rtl/pipe_ctrl_gen.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_gen_if.sv
// Stall/flush control bundle between the pipeline and its stall/flush controller.
//   master : the controller (pipe_ctrl_gen); samples requests, drives stall/flush/redirect/status.
//   slave  : the pipeline side; drives requests and clears, consumes stall/flush/redirect/status.
// Signals:
//   stallreq[STAGES]  per-stage stall request          flush_req/flush_pc  exception redirect
//   timeout_clr       clear sticky watchdog flag       perf_clr            clear stall counter
//   stall[STAGES]     per-stage hold enable            flush/new_pc        flush pulse + redirect PC
//   stall_timeout     sticky watchdog flag             stall_cnt           saturating stall cycles
interface pipe_ctrl_gen_if #(
  parameter int unsigned STAGES = 6,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 32
);
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic              timeout_clr;
  logic              perf_clr;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  stallreq, flush_req, flush_pc, timeout_clr, perf_clr,
    output stall, flush, new_pc, stall_timeout, stall_cnt
  );

  modport slave (
    output stallreq, flush_req, flush_pc, timeout_clr, perf_clr,
    input  stall, flush, new_pc, stall_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller for the in-order CPU.
// The highest requesting stage freezes itself and all upstream stages (combinational).
// An exception flush sequencer latches the redirect PC and holds flush for FLUSH_LEN cycles;
// flush activity overrides all stall requests. Also provides a sticky stall watchdog and a
// saturating count of cycles in which the PC stage is held.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  pipe_ctrl_gen_if.master (requests in; stall, flush, new_pc, stall_timeout, stall_cnt out)
module pipe_ctrl_gen #(
  parameter int unsigned STAGES    = 6,
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_gen_if.master  bus
);

  localparam int unsigned LEN_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_cnt;
  logic [LEN_W-1:0]  len_nxt;
  logic              flush_q;
  logic              flush_nxt;
  logic [PC_W-1:0]   new_pc_q;
  logic [PC_W-1:0]   new_pc_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              timeout_q;
  logic [CNT_W-1:0]  perf_q;
  logic [STAGES-1:0] prio_c;
  logic [STAGES-1:0] stall_c;
  logic              flushing_c;

  // Thermometer from the highest request down to stage 0.
  always_comb begin
    prio_c = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      prio_c[i] = |(bus.stallreq >> i);
    end
  end

  // Any flush activity (new request or ongoing sequence) releases every stage.
  assign flushing_c = bus.flush_req || (state == FLUSH);
  assign stall_c    = (!rst || flushing_c) ? '0 : prio_c;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; requests arriving in FLUSH (including the exit cycle) are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.flush_req)     state_nxt = FLUSH;
      FLUSH: if (len_cnt == '0)     state_nxt = IDLE;
    endcase
  end

  // Next values of the registered flush outputs and the length counter.
  always_comb begin
    flush_nxt  = flush_q;
    new_pc_nxt = new_pc_q;
    len_nxt    = len_cnt;
    case (state)
      IDLE: begin
        if (bus.flush_req) begin
          flush_nxt  = 1'b1;
          new_pc_nxt = bus.flush_pc;
          len_nxt    = LEN_W'(FLUSH_LEN - 1);
        end
      end
      FLUSH: begin
        if (len_cnt != '0) len_nxt   = len_cnt - LEN_W'(1);
        else               flush_nxt = 1'b0;
      end
    endcase
  end

  // Flush output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      len_cnt  <= '0;
    end else begin
      flush_q  <= flush_nxt;
      new_pc_q <= new_pc_nxt;
      len_cnt  <= len_nxt;
    end
  end

  // Watchdog: flag trips on the edge the consecutive-stall count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (bus.timeout_clr) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (stall_c == '0) begin
      wd_cnt    <= '0;
    end else begin
      if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt >= WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
    end
  end

  // Saturating count of cycles with the PC stage held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              perf_q <= '0;
    else if (bus.perf_clr)                 perf_q <= '0;
    else if (stall_c[0] && (perf_q != '1)) perf_q <= perf_q + CNT_W'(1);
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.stall_cnt     = perf_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen (STAGES=6, FLUSH_LEN=2, TIMEOUT=16, CNT_W=4).
module tb_pipe_ctrl_gen;

  localparam int unsigned STAGES    = 6;
  localparam int unsigned FLUSH_LEN = 2;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned CNT_W     = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipe_ctrl_gen_if #(.STAGES(STAGES), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pipe_ctrl_gen #(
    .STAGES(STAGES), .FLUSH_LEN(FLUSH_LEN), .TIMEOUT(TIMEOUT), .PC_W(PC_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b0;
    bus.stallreq    = 6'b001000;
    bus.flush_req   = 1'b0;
    bus.flush_pc    = '0;
    bus.timeout_clr = 1'b0;
    bus.perf_clr    = 1'b0;

    // Reset state
    #1;
    check("rst_stall",   64'(bus.stall), 64'h0);
    check("rst_flush",   64'(bus.flush), 64'h0);
    check("rst_new_pc",  64'(bus.new_pc), 64'h0);
    check("rst_timeout", 64'(bus.stall_timeout), 64'h0);
    check("rst_cnt",     64'(bus.stall_cnt), 64'h0);
    bus.stallreq = '0;
    tick(2);
    rst = 1'b1;
    tick(1);

    // Priority encoding, zero latency
    bus.stallreq = 6'b001010; #1; check("prio_001010", 64'(bus.stall), 64'b001111);
    bus.stallreq = 6'b000100; #1; check("prio_000100", 64'(bus.stall), 64'b000111);
    bus.stallreq = 6'b100001; #1; check("prio_100001", 64'(bus.stall), 64'b111111);
    bus.stallreq = 6'b000001; #1; check("prio_000001", 64'(bus.stall), 64'b000001);
    bus.stallreq = 6'b000000; #1; check("prio_none",   64'(bus.stall), 64'b000000);
    tick(1);

    // Flush with stall request held; nested and exit-edge requests ignored
    bus.stallreq  = 6'b001000;
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'h0000_1000;
    #1;
    check("fl_req_stall", 64'(bus.stall), 64'h0);
    check("fl_req_flush", 64'(bus.flush), 64'h0);
    tick(1);
    bus.flush_req = 1'b0;
    #1;
    check("fl_c1_flush",  64'(bus.flush), 64'h1);
    check("fl_c1_pc",     64'(bus.new_pc), 64'h1000);
    check("fl_c1_stall",  64'(bus.stall), 64'h0);
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'h0000_2000;
    tick(1);
    check("fl_c2_flush",  64'(bus.flush), 64'h1);
    check("fl_c2_pc",     64'(bus.new_pc), 64'h1000);
    check("fl_c2_stall",  64'(bus.stall), 64'h0);
    bus.flush_pc  = 32'h0000_3000;
    tick(1);
    bus.flush_req = 1'b0;
    #1;
    check("fl_end_flush", 64'(bus.flush), 64'h0);
    check("fl_end_pc",    64'(bus.new_pc), 64'h1000);
    check("fl_end_stall", 64'(bus.stall), 64'b001111);
    tick(1);
    check("fl_after",     64'(bus.flush), 64'h0);

    // Clear counters before watchdog runs
    bus.stallreq    = '0;
    bus.perf_clr    = 1'b1;
    bus.timeout_clr = 1'b1;
    tick(1);
    bus.perf_clr    = 1'b0;
    bus.timeout_clr = 1'b0;
    check("clr_cnt", 64'(bus.stall_cnt), 64'h0);

    // Watchdog: 15 stalled cycles no trip, 16th trips, sticky after release
    bus.stallreq = 6'b001000;
    tick(15);
    check("wd_15",      64'(bus.stall_timeout), 64'h0);
    check("perf_sat15", 64'(bus.stall_cnt), 64'd15);
    tick(1);
    check("wd_16",      64'(bus.stall_timeout), 64'h1);
    check("perf_sat16", 64'(bus.stall_cnt), 64'd15);
    bus.stallreq = '0;
    tick(3);
    check("wd_sticky",  64'(bus.stall_timeout), 64'h1);
    bus.timeout_clr = 1'b1;
    tick(1);
    bus.timeout_clr = 1'b0;
    check("wd_clr",     64'(bus.stall_timeout), 64'h0);

    // Clear coincident with trip edge: clear wins
    bus.stallreq = 6'b001000;
    tick(15);
    bus.timeout_clr = 1'b1;
    tick(1);
    bus.timeout_clr = 1'b0;
    check("wd_clr_wins", 64'(bus.stall_timeout), 64'h0);
    bus.stallreq = '0;
    tick(1);

    // Perf clear during stalling, then resume and saturate
    bus.stallreq = 6'b000001;
    bus.perf_clr = 1'b1;
    tick(1);
    bus.perf_clr = 1'b0;
    check("perf_clr",    64'(bus.stall_cnt), 64'h0);
    tick(1);
    check("perf_resume", 64'(bus.stall_cnt), 64'h1);
    tick(3);
    check("perf_4",      64'(bus.stall_cnt), 64'h4);
    tick(18);
    check("perf_sat",    64'(bus.stall_cnt), 64'd15);
    check("wd_long",     64'(bus.stall_timeout), 64'h1);

    // Async reset mid-flush and mid-stall
    bus.stallreq  = 6'b001000;
    bus.flush_req = 1'b1;
    bus.flush_pc  = 32'h0000_4000;
    tick(1);
    bus.flush_req = 1'b0;
    #1;
    check("rf_flush_pre", 64'(bus.flush), 64'h1);
    #1;
    rst = 1'b0;
    #1;
    check("rf_flush",   64'(bus.flush), 64'h0);
    check("rf_new_pc",  64'(bus.new_pc), 64'h0);
    check("rf_cnt",     64'(bus.stall_cnt), 64'h0);
    check("rf_timeout", 64'(bus.stall_timeout), 64'h0);
    check("rf_stall",   64'(bus.stall), 64'h0);
    #1;
    rst = 1'b1;
    tick(1);
    check("rf_post_flush1", 64'(bus.flush), 64'h0);
    check("rf_post_stall",  64'(bus.stall), 64'b001111);
    tick(2);
    check("rf_post_flush3", 64'(bus.flush), 64'h0);
    check("rf_post_cnt",    64'(bus.stall_cnt), 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
